aibcr4_io_digital_mc: RTL and testbench

- Multi-channel successor to the single-pad AIB IO digital wrapper.
- Serves NCH pads. Each pad gets an N:1 TX serializer (generalising the DDR idat0/idat1 pair) and a 1:N RX deserializer.
- A per-channel TX enable FSM gates output enable, drive strength and weak pulls, with all changes aligned to word boundaries.
- Sits between the adapter parallel data path and the analog IO buffers, one instance per IO column group.

---
 rtl/aibcr4_dig_pkg.sv | 21 ++
 rtl/aibcr4_dig_chan.sv | 124 ++++++++++++
 rtl/aibcr4_io_digital_mc.sv | 97 +++++++++
 tb/tb_aibcr4_io_digital_mc.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aibcr4_dig_pkg.sv
// Shared types and constants for the multi-channel AIB IO digital wrapper.
package aibcr4_dig_pkg;

    localparam int unsigned DEF_NCH       = 4;
    localparam int unsigned DEF_SER_RATIO = 4;
    localparam int unsigned DEF_STRW      = 2;

    // Per-channel TX enable sequencing
    typedef enum logic [1:0] {
        TX_OFF   = 2'd0,
        TX_ARM   = 2'd1,
        TX_DRIVE = 2'd2,
        TX_DRAIN = 2'd3
    } tx_state_t;

    // Width of the shared word-phase counter
    function automatic int unsigned ph_width(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/aibcr4_dig_chan.sv
// One pad channel: TX enable FSM, N:1 serializer, 1:N deserializer, weak pulls.
module aibcr4_dig_chan
    import aibcr4_dig_pkg::*;
#(
    parameter int unsigned SER_RATIO = DEF_SER_RATIO,
    parameter int unsigned STRW      = DEF_STRW,
    parameter int unsigned PHW       = ph_width(SER_RATIO)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pad_rst_n,
    input  logic                 word_edge,
    input  logic [PHW-1:0]       ph_nxt,
    input  logic                 tx_en,
    input  logic                 rx_en,
    input  logic                 lpbk_en,
    input  logic [SER_RATIO-1:0] dat,
    input  logic [STRW-1:0]      pdrv,
    input  logic [STRW-1:0]      ndrv,
    input  logic                 rx_in,
    input  logic                 weakpu,
    input  logic                 weakpd,
    output logic                 tx_dat,
    output logic                 tx_en_buf,
    output logic [STRW-1:0]      pdrv_buf,
    output logic [STRW-1:0]      ndrv_buf,
    output logic                 weak_pullupenb,
    output logic                 weak_pulldownen,
    output logic                 rx_disable,
    output logic [SER_RATIO-1:0] odat
);

    tx_state_t            state;
    tx_state_t            state_nxt;
    logic [SER_RATIO-1:0] tx_sh;
    logic [SER_RATIO-1:0] tx_sh_nxt;
    logic [SER_RATIO-1:0] rx_sh;
    logic [SER_RATIO-1:0] rx_shifted;
    logic                 active_nxt;
    logic                 tx_dat_nxt;
    logic                 rx_src;
    logic                 rx_disable_nxt;
    logic                 pullupenb_nxt;
    logic                 pulldownen_nxt;
    logic [STRW-1:0]      pdrv_nxt;
    logic [STRW-1:0]      ndrv_nxt;

    // Next-state and next-output decode; every output is registered from the next state
    always_comb begin
        state_nxt      = state;
        tx_sh_nxt      = tx_sh;
        active_nxt     = 1'b0;
        tx_dat_nxt     = 1'b0;
        rx_src         = rx_in;
        rx_shifted     = '0;
        rx_disable_nxt = 1'b1;
        pullupenb_nxt  = 1'b1;
        pulldownen_nxt = 1'b0;
        pdrv_nxt       = '0;
        ndrv_nxt       = '0;

        if (!pad_rst_n) begin
            state_nxt = TX_OFF;
        end else begin
            case (state)
                TX_OFF:   if (tx_en) state_nxt = TX_ARM;
                TX_ARM:   if (!tx_en) state_nxt = TX_OFF;
                          else if (word_edge) state_nxt = TX_DRIVE;
                TX_DRIVE: if (!tx_en) state_nxt = word_edge ? TX_OFF : TX_DRAIN;
                TX_DRAIN: if (tx_en) state_nxt = TX_DRIVE;
                          else if (word_edge) state_nxt = TX_OFF;
                default:  state_nxt = TX_OFF;
            endcase
        end

        // New word is captured only on the boundary that starts a DRIVE word
        if (word_edge && (state_nxt == TX_DRIVE)) tx_sh_nxt = dat;

        active_nxt = (state_nxt == TX_DRIVE) || (state_nxt == TX_DRAIN);
        tx_dat_nxt = active_nxt & tx_sh_nxt[ph_nxt];
        pdrv_nxt   = active_nxt ? pdrv : '0;
        ndrv_nxt   = active_nxt ? ndrv : '0;

        // Opposing weak-pull requests cancel so both devices are never on
        if (!active_nxt) begin
            pullupenb_nxt  = ~(weakpu & ~weakpd);
            pulldownen_nxt = weakpd & ~weakpu;
        end

        rx_src         = lpbk_en ? tx_dat : rx_in;
        rx_shifted     = {rx_src, rx_sh[SER_RATIO-1:1]};
        rx_disable_nxt = lpbk_en ? ~rx_en : (~rx_en | (state_nxt != TX_OFF));
    end

    // State, shift registers and registered pad-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= TX_OFF;
            tx_sh           <= '0;
            rx_sh           <= '0;
            odat            <= '0;
            tx_dat          <= 1'b0;
            tx_en_buf       <= 1'b0;
            pdrv_buf        <= '0;
            ndrv_buf        <= '0;
            weak_pullupenb  <= 1'b1;
            weak_pulldownen <= 1'b0;
            rx_disable      <= 1'b1;
        end else begin
            state           <= state_nxt;
            tx_sh           <= tx_sh_nxt;
            tx_dat          <= tx_dat_nxt;
            tx_en_buf       <= active_nxt;
            pdrv_buf        <= pdrv_nxt;
            ndrv_buf        <= ndrv_nxt;
            weak_pullupenb  <= pullupenb_nxt;
            weak_pulldownen <= pulldownen_nxt;
            rx_disable      <= rx_disable_nxt;
            rx_sh           <= rx_disable ? '0 : rx_shifted;
            if (word_edge) odat <= rx_disable ? '0 : rx_shifted;
        end
    end

endmodule

// File: rtl/aibcr4_io_digital_mc.sv
// Multi-channel AIB IO digital wrapper: shared word phase plus NCH pad channels.
// Optional internal TX->RX loopback enabled by defining AIB_DIG_LPBK_EN.
module aibcr4_io_digital_mc
    import aibcr4_dig_pkg::*;
#(
    parameter int unsigned NCH       = DEF_NCH,
    parameter int unsigned SER_RATIO = DEF_SER_RATIO,
    parameter int unsigned STRW      = DEF_STRW
) (
    input  logic                     ilaunch_clk,
    input  logic                     irstb,
`ifdef AIB_DIG_LPBK_EN
    input  logic                     ilpbk_en,
`endif
    input  logic                     ipadrstb,
    input  logic [NCH-1:0]           itx_en,
    input  logic [NCH-1:0]           irxen,
    input  logic [NCH*SER_RATIO-1:0] idat,
    input  logic [NCH*STRW-1:0]      ipdrv,
    input  logic [NCH*STRW-1:0]      indrv,
    input  logic [NCH-1:0]           rx_idat,
    input  logic                     test_weakpu,
    input  logic                     test_weakpd,
    output logic                     word_stb,
    output logic [NCH-1:0]           tx_dat,
    output logic [NCH-1:0]           itx_en_buf,
    output logic [NCH*STRW-1:0]      ipdrv_buf,
    output logic [NCH*STRW-1:0]      indrv_buf,
    output logic [NCH-1:0]           weak_pullupenb,
    output logic [NCH-1:0]           weak_pulldownen,
    output logic [NCH-1:0]           rx_disable,
    output logic [NCH*SER_RATIO-1:0] odat,
    output logic                     odat_vld
);

    localparam int unsigned    PHW     = ph_width(SER_RATIO);
    localparam logic [PHW-1:0] PH_LAST = PHW'(SER_RATIO - 1);

    logic [PHW-1:0] ph;
    logic [PHW-1:0] ph_nxt;
    logic           word_edge;
    logic           lpbk_sel;

`ifdef AIB_DIG_LPBK_EN
    assign lpbk_sel = ilpbk_en;
`else
    assign lpbk_sel = 1'b0;
`endif

    assign word_edge = (ph == PH_LAST);
    assign ph_nxt    = word_edge ? '0 : ph + PHW'(1);

    // Shared word phase, word strobe and RX word-valid pulse
    always_ff @(posedge ilaunch_clk or negedge irstb) begin
        if (!irstb) begin
            ph       <= '0;
            word_stb <= 1'b0;
            odat_vld <= 1'b0;
        end else begin
            ph       <= ph_nxt;
            word_stb <= (ph_nxt == PH_LAST);
            odat_vld <= word_edge;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        aibcr4_dig_chan #(
            .SER_RATIO (SER_RATIO),
            .STRW      (STRW),
            .PHW       (PHW)
        ) u_chan (
            .clk             (ilaunch_clk),
            .rst_n           (irstb),
            .pad_rst_n       (ipadrstb),
            .word_edge       (word_edge),
            .ph_nxt          (ph_nxt),
            .tx_en           (itx_en[c]),
            .rx_en           (irxen[c]),
            .lpbk_en         (lpbk_sel),
            .dat             (idat[c*SER_RATIO +: SER_RATIO]),
            .pdrv            (ipdrv[c*STRW +: STRW]),
            .ndrv            (indrv[c*STRW +: STRW]),
            .rx_in           (rx_idat[c]),
            .weakpu          (test_weakpu),
            .weakpd          (test_weakpd),
            .tx_dat          (tx_dat[c]),
            .tx_en_buf       (itx_en_buf[c]),
            .pdrv_buf        (ipdrv_buf[c*STRW +: STRW]),
            .ndrv_buf        (indrv_buf[c*STRW +: STRW]),
            .weak_pullupenb  (weak_pullupenb[c]),
            .weak_pulldownen (weak_pulldownen[c]),
            .rx_disable      (rx_disable[c]),
            .odat            (odat[c*SER_RATIO +: SER_RATIO])
        );
    end

endmodule

// File: tb/tb_aibcr4_io_digital_mc.sv
// Randomized self-checking bench for aibcr4_io_digital_mc against a cycle-level reference model.
module tb_aibcr4_io_digital_mc;

    localparam int NCH  = 4;
    localparam int R    = 4;
    localparam int STRW = 2;

    localparam int M_OFF   = 0;
    localparam int M_ARM   = 1;
    localparam int M_DRIVE = 2;
    localparam int M_DRAIN = 3;

    logic                ilaunch_clk = 1'b0;
    logic                irstb;
    logic                ipadrstb;
    logic [NCH-1:0]      itx_en;
    logic [NCH-1:0]      irxen;
    logic [NCH*R-1:0]    idat;
    logic [NCH*STRW-1:0] ipdrv;
    logic [NCH*STRW-1:0] indrv;
    logic [NCH-1:0]      rx_idat;
    logic                test_weakpu;
    logic                test_weakpd;
    logic                word_stb;
    logic [NCH-1:0]      tx_dat;
    logic [NCH-1:0]      itx_en_buf;
    logic [NCH*STRW-1:0] ipdrv_buf;
    logic [NCH*STRW-1:0] indrv_buf;
    logic [NCH-1:0]      weak_pullupenb;
    logic [NCH-1:0]      weak_pulldownen;
    logic [NCH-1:0]      rx_disable;
    logic [NCH*R-1:0]    odat;
    logic                odat_vld;
    logic                lpbk_now;

`ifdef AIB_DIG_LPBK_EN
    logic ilpbk_en;
    assign lpbk_now = ilpbk_en;
`else
    assign lpbk_now = 1'b0;
`endif

    aibcr4_io_digital_mc #(.NCH(NCH), .SER_RATIO(R), .STRW(STRW)) dut (
        .ilaunch_clk     (ilaunch_clk),
        .irstb           (irstb),
`ifdef AIB_DIG_LPBK_EN
        .ilpbk_en        (ilpbk_en),
`endif
        .ipadrstb        (ipadrstb),
        .itx_en          (itx_en),
        .irxen           (irxen),
        .idat            (idat),
        .ipdrv           (ipdrv),
        .indrv           (indrv),
        .rx_idat         (rx_idat),
        .test_weakpu     (test_weakpu),
        .test_weakpd     (test_weakpd),
        .word_stb        (word_stb),
        .tx_dat          (tx_dat),
        .itx_en_buf      (itx_en_buf),
        .ipdrv_buf       (ipdrv_buf),
        .indrv_buf       (indrv_buf),
        .weak_pullupenb  (weak_pullupenb),
        .weak_pulldownen (weak_pulldownen),
        .rx_disable      (rx_disable),
        .odat            (odat),
        .odat_vld        (odat_vld)
    );

    always #5 ilaunch_clk = ~ilaunch_clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: word phase, per-channel mode, current TX word, RX bits by phase
    int                  m_ph;
    int                  m_mode [NCH];
    logic [R-1:0]        m_word [NCH];
    logic [R-1:0]        m_acc  [NCH];
    logic [NCH-1:0]      e_txdat, e_txen, e_pu, e_pd, e_rxdis;
    logic [NCH*STRW-1:0] e_pdrv, e_ndrv;
    logic [NCH*R-1:0]    e_odat;
    logic                e_vld, e_stb;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0;
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = M_OFF;
            m_word[c] = '0;
            m_acc[c]  = '0;
        end
        e_txdat = '0; e_txen = '0; e_pu = '1; e_pd = '0; e_rxdis = '1;
        e_pdrv = '0; e_ndrv = '0; e_odat = '0; e_vld = 1'b0; e_stb = 1'b0;
    endtask

    // One clock edge of the reference model, using the inputs currently applied
    task automatic model_edge();
        bit last;
        int ph_n;
        int nm;
        bit act;
        bit src;
        last = (m_ph == R - 1);
        ph_n = last ? 0 : m_ph + 1;
        for (int c = 0; c < NCH; c++) begin
            nm = m_mode[c];
            if (!ipadrstb) nm = M_OFF;
            else begin
                case (m_mode[c])
                    M_OFF:   if (itx_en[c]) nm = M_ARM;
                    M_ARM:   nm = !itx_en[c] ? M_OFF : (last ? M_DRIVE : M_ARM);
                    M_DRIVE: if (!itx_en[c]) nm = last ? M_OFF : M_DRAIN;
                    default: nm = itx_en[c] ? M_DRIVE : (last ? M_OFF : M_DRAIN);
                endcase
            end
            act = (nm == M_DRIVE) || (nm == M_DRAIN);
            src = lpbk_now ? e_txdat[c] : rx_idat[c];
            if (e_rxdis[c]) m_acc[c] = '0;
            else m_acc[c][m_ph] = src;
            if (last) e_odat[c*R +: R] = e_rxdis[c] ? '0 : m_acc[c];
            if (last && nm == M_DRIVE) m_word[c] = idat[c*R +: R];
            e_txdat[c] = act ? m_word[c][ph_n] : 1'b0;
            e_txen[c]  = act;
            e_pdrv[c*STRW +: STRW] = act ? ipdrv[c*STRW +: STRW] : '0;
            e_ndrv[c*STRW +: STRW] = act ? indrv[c*STRW +: STRW] : '0;
            e_pu[c]    = act ? 1'b1 : ~(test_weakpu & ~test_weakpd);
            e_pd[c]    = act ? 1'b0 : (test_weakpd & ~test_weakpu);
            e_rxdis[c] = lpbk_now ? ~irxen[c] : (~irxen[c] | (nm != M_OFF));
            m_mode[c]  = nm;
        end
        e_vld = last;
        e_stb = (ph_n == R - 1);
        m_ph  = ph_n;
    endtask

    task automatic compare_all();
        check_val("word_stb",   64'(word_stb),        64'(e_stb));
        check_val("odat_vld",   64'(odat_vld),        64'(e_vld));
        check_val("tx_dat",     64'(tx_dat),          64'(e_txdat));
        check_val("itx_en_buf", 64'(itx_en_buf),      64'(e_txen));
        check_val("ipdrv_buf",  64'(ipdrv_buf),       64'(e_pdrv));
        check_val("indrv_buf",  64'(indrv_buf),       64'(e_ndrv));
        check_val("pullupenb",  64'(weak_pullupenb),  64'(e_pu));
        check_val("pulldownen", 64'(weak_pulldownen), 64'(e_pd));
        check_val("rx_disable", 64'(rx_disable),      64'(e_rxdis));
        check_val("odat",       64'(odat),            64'(e_odat));
    endtask

    // Inputs are changed at the negedge; the model steps at the posedge; outputs checked 1 after
    task automatic cycle();
        @(posedge ilaunch_clk);
        model_edge();
        #1;
        compare_all();
        @(negedge ilaunch_clk);
    endtask

    task automatic randomize_inputs();
        for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(7, 0) == 0)  itx_en[c] = ~itx_en[c];
            if ($urandom_range(15, 0) == 0) irxen[c]  = ~irxen[c];
        end
        idat     = NCH*R'($urandom);
        ipdrv    = NCH*STRW'($urandom);
        indrv    = NCH*STRW'($urandom);
        rx_idat  = NCH'($urandom);
        ipadrstb = ($urandom_range(39, 0) != 0);
        if ($urandom_range(7, 0) == 0) test_weakpu = ~test_weakpu;
        if ($urandom_range(7, 0) == 0) test_weakpd = ~test_weakpd;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_tx_dat"},  64'(tx_dat),          64'(0));
        check_val({tag, "_oe"},      64'(itx_en_buf),      64'(0));
        check_val({tag, "_pdrv"},    64'(ipdrv_buf),       64'(0));
        check_val({tag, "_pu"},      64'(weak_pullupenb),  64'(4'hF));
        check_val({tag, "_pd"},      64'(weak_pulldownen), 64'(0));
        check_val({tag, "_rxdis"},   64'(rx_disable),      64'(4'hF));
        check_val({tag, "_odat"},    64'(odat),            64'(0));
        check_val({tag, "_vld"},     64'(odat_vld),        64'(0));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        logic [R-1:0] pat;
        irstb = 1'b0; ipadrstb = 1'b1; itx_en = '0; irxen = '0; idat = '0;
        ipdrv = '0; indrv = '0; rx_idat = '0; test_weakpu = 1'b0; test_weakpd = 1'b0;
`ifdef AIB_DIG_LPBK_EN
        ilpbk_en = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge ilaunch_clk);
        check_reset_outputs("init");
        irstb = 1'b1;

        // RX word on channel 2 with TX off: bits 0,1,1,0 at ph 0..3
        irxen = 4'b0100;
        pat = 4'b0110;
        for (int i = 0; i < 3 * R; i++) begin
            rx_idat = '0;
            rx_idat[2] = pat[m_ph];
            cycle();
        end
        for (int i = 0; i < R && m_ph != 0; i++) begin
            rx_idat[2] = pat[m_ph];
            cycle();
        end
        check_val("dir_rx_word", 64'(odat[11:8]), 64'(4'b0110));
        check_val("dir_rx_vld",  64'(odat_vld),   64'(1));
        rx_idat[2] = pat[m_ph];
        cycle();
        check_val("dir_rx_vld_once", 64'(odat_vld), 64'(0));

        // Channel 0 TX: enable rises at ph 1, word 1011 sent LSB first
        irxen = 4'b0001;
        pat = 4'b1011;
        idat = '0;
        idat[3:0] = pat;
        for (int i = 0; i < R && m_ph != 1; i++) cycle();
        itx_en[0] = 1'b1;
        cycle();
        cycle();
        check_val("dir_arm_oe", 64'(itx_en_buf[0]), 64'(0));
        cycle();
        check_val("dir_drive_oe", 64'(itx_en_buf[0]), 64'(1));
        for (int k = 0; k < R; k++) begin
            if (k > 0) cycle();
            check_val("dir_tx_bit", 64'(tx_dat[0]), 64'(pat[k]));
        end

        // Drop enable at ph 1: remaining two bits drain, then OFF at the word edge
        cycle();
        cycle();
        itx_en[0] = 1'b0;
        cycle();
        check_val("dir_drain_oe",   64'(itx_en_buf[0]), 64'(1));
        check_val("dir_drain_bit2", 64'(tx_dat[0]),     64'(pat[2]));
        cycle();
        check_val("dir_drain_bit3", 64'(tx_dat[0]),     64'(pat[3]));
        cycle();
        check_val("dir_off_oe",    64'(itx_en_buf[0]), 64'(0));
        check_val("dir_off_rxdis", 64'(rx_disable[0]), 64'(0));
        check_val("dir_off_tx",    64'(tx_dat[0]),     64'(0));

        // Pad reset while all channels drive, with both weak pulls requested
        itx_en = '1; idat = '1; ipdrv = '1; indrv = '1;
        repeat (2 * R) cycle();
        check_val("dir_all_oe", 64'(itx_en_buf), 64'(4'hF));
        test_weakpu = 1'b1; test_weakpd = 1'b1; ipadrstb = 1'b0;
        cycle();
        check_val("dir_padrst_tx",   64'(tx_dat),          64'(0));
        check_val("dir_padrst_pdrv", 64'(ipdrv_buf),       64'(0));
        check_val("dir_padrst_ndrv", 64'(indrv_buf),       64'(0));
        check_val("dir_padrst_pu",   64'(weak_pullupenb),  64'(4'hF));
        check_val("dir_padrst_pd",   64'(weak_pulldownen), 64'(0));
        ipadrstb = 1'b1; test_weakpu = 1'b0; test_weakpd = 1'b0;

        // Asynchronous reset mid-DRIVE
        irxen = '1;
        repeat (2 * R + 1) cycle();
        check_val("dir_ch1_drive", 64'(itx_en_buf[1]), 64'(1));
        #2;
        irstb = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(negedge ilaunch_clk);
        @(negedge ilaunch_clk);
        irstb = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            randomize_inputs();
            cycle();
        end

`ifdef AIB_DIG_LPBK_EN
        // Loopback: directed words on channel 3, then random traffic
        ilpbk_en = 1'b1; ipadrstb = 1'b1; irxen = '1; itx_en = '1;
        for (int w = 0; w < 6; w++) begin
            idat[15:12] = (w % 3 == 0) ? 4'h5 : ((w % 3 == 1) ? 4'hA : 4'h3);
            repeat (R) cycle();
        end
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            cycle();
        end
        ilpbk_en = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
